// File: rtl/alu_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_unit_if                                                              |
// | Issue/result bundle between a reservation station and alu_unit.          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface alu_unit_if #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       op;
  logic [XLEN-1:0]  r1;
  logic [XLEN-1:0]  r2;
  logic [ROB_W-1:0] in_rob_id;
  logic             out_valid;
  logic [ROB_W-1:0] out_rob_id;
  logic [XLEN-1:0]  out_value;

  modport master (
    output in_valid, op, r1, r2, in_rob_id,
    input  in_ready, out_valid, out_rob_id, out_value
  );

  modport slave (
    input  in_valid, op, r1, r2, in_rob_id,
    output in_ready, out_valid, out_rob_id, out_value
  );
endinterface
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_unit                                                                 |
// | RV integer ALU / branch compare with optional M extension. Results are   |
// | tagged with the ROB id. Divides use an iterative radix-2 restoring       |
// | divider that holds off issue via in_ready; flush kills it.               |
// | Optional feature macro: ALU_MULDIV_EN (mul/div datapath and FSM).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_unit #(
  parameter int XLEN  = 32,
  parameter int ROB_W = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rdy_i,
  input  logic      flush_i,
  alu_unit_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  logic [2:0]      f3;
  logic [SHW-1:0]  shamt;
  logic            lt_s, lt_u, eq;
  logic [XLEN-1:0] sra_res;
  logic [XLEN-1:0] alu_res, br_res, res_now;
  logic            br_bit;
  logic            accept;
  logic            completes_now;
  logic            out_valid_q;
  logic [ROB_W-1:0] out_rob_q;
  logic [XLEN-1:0] out_value_q;

  assign f3      = bus.op[2:0];
  assign shamt   = bus.r2[SHW-1:0];
  assign lt_s    = $signed(bus.r1) < $signed(bus.r2);
  assign lt_u    = bus.r1 < bus.r2;
  assign eq      = bus.r1 == bus.r2;
  // Kept separate so the arithmetic shift is evaluated in a signed context
  assign sra_res = $signed(bus.r1) >>> shamt;
  assign accept  = bus.in_valid & bus.in_ready & rdy_i & ~flush_i;

  // Integer ALU result selected by funct3 (op[3] picks sub / sra)
  always_comb begin
    alu_res = '0;
    case (f3)
      3'b000:  alu_res = bus.op[3] ? (bus.r1 - bus.r2) : (bus.r1 + bus.r2);
      3'b001:  alu_res = bus.r1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  alu_res = bus.r1 ^ bus.r2;
      3'b101:  alu_res = bus.op[3] ? sra_res : (bus.r1 >> shamt);
      3'b110:  alu_res = bus.r1 | bus.r2;
      default: alu_res = bus.r1 & bus.r2;
    endcase
  end

  // Branch comparison producing a zero-extended 0/1
  always_comb begin
    br_bit = 1'b0;
    case (f3)
      3'b000:  br_bit = eq;
      3'b001:  br_bit = ~eq;
      3'b100:  br_bit = lt_s;
      3'b101:  br_bit = ~lt_s;
      3'b110:  br_bit = lt_u;
      3'b111:  br_bit = ~lt_u;
      default: br_bit = 1'b0;
    endcase
  end
  assign br_res = {{(XLEN-1){1'b0}}, br_bit};

`ifdef ALU_MULDIV_EN
  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] XMIN     = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [SHW-1:0]  count_q;
  logic [XLEN-1:0] quo_q, rem_q, dvs_q;
  logic [ROB_W-1:0] tag_q;
  logic            is_rem_q, neg_quo_q, neg_rem_q;

  // Every product fits in 2*XLEN bits two's complement, so the operands are
  // extended to that width and a single multiplier serves all four forms.
  logic            a_sgn, b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, mul_p;
  logic            div_sgn, div_zero, div_ovf, is_div, div_start;
  logic [XLEN-1:0] r1_mag, r2_mag, special_res, md_res;
  logic [XLEN:0]   rem_shift, rem_diff;
  logic [XLEN-1:0] quo_fix, rem_fix;

  assign a_sgn     = (f3 == 3'b001) || (f3 == 3'b010);
  assign b_sgn     = (f3 == 3'b001);
  assign mul_a     = {{XLEN{a_sgn & bus.r1[XLEN-1]}}, bus.r1};
  assign mul_b     = {{XLEN{b_sgn & bus.r2[XLEN-1]}}, bus.r2};
  assign mul_p     = mul_a * mul_b;

  assign div_sgn   = ~f3[0];
  assign div_zero  = (bus.r2 == '0);
  assign div_ovf   = div_sgn & (bus.r1 == XMIN) & (&bus.r2);
  assign r1_mag    = (div_sgn & bus.r1[XLEN-1]) ? -bus.r1 : bus.r1;
  assign r2_mag    = (div_sgn & bus.r2[XLEN-1]) ? -bus.r2 : bus.r2;
  // f3[1] selects remainder; overflow gives quotient MIN / remainder 0
  assign special_res = f3[1] ? (div_zero ? bus.r1 : '0)
                             : (div_zero ? '1 : XMIN);
  assign is_div    = bus.op[5] & f3[2];
  assign completes_now = ~is_div | div_zero | div_ovf;
  assign div_start = accept & ~completes_now;
  assign bus.in_ready = (state_q == S_IDLE);

  // M-extension result for the ops that finish in one edge
  always_comb begin
    md_res = special_res;
    case (f3)
      3'b000:  md_res = mul_p[XLEN-1:0];
      3'b001,
      3'b010,
      3'b011:  md_res = mul_p[2*XLEN-1:XLEN];
      default: md_res = special_res;
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits
  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};
  assign quo_fix   = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix   = neg_rem_q ? -rem_q : rem_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state: flush wins over the enable, rdy=0 freezes the sequence
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else if (rdy_i) begin
      case (state_q)
        S_IDLE:  if (div_start) state_d = S_DIV;
        S_DIV:   if (count_q == CNT_LAST) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Divider datapath: load magnitudes on start, one step per enabled DIV edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      tag_q     <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (rdy_i && !flush_i) begin
      if (state_q == S_IDLE) begin
        if (div_start) begin
          count_q   <= '0;
          quo_q     <= r1_mag;
          rem_q     <= '0;
          dvs_q     <= r2_mag;
          tag_q     <= bus.in_rob_id;
          is_rem_q  <= f3[1];
          neg_quo_q <= div_sgn & (bus.r1[XLEN-1] ^ bus.r2[XLEN-1]);
          neg_rem_q <= div_sgn & bus.r1[XLEN-1];
        end
      end else if (state_q == S_DIV) begin
        count_q <= count_q + 1'b1;
        if (!rem_diff[XLEN]) begin
          rem_q <= rem_diff[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b1};
        end else begin
          rem_q <= rem_shift[XLEN-1:0];
          quo_q <= {quo_q[XLEN-2:0], 1'b0};
        end
      end
    end
  end
`else
  assign completes_now = 1'b1;
  assign bus.in_ready  = 1'b1;
`endif

  // Result selection for anything completing on the accept edge
  always_comb begin
    res_now = '0;
    if (bus.op[5]) begin
`ifdef ALU_MULDIV_EN
      res_now = md_res;
`else
      res_now = '0;
`endif
    end else if (bus.op[4]) begin
      res_now = br_res;
    end else begin
      res_now = alu_res;
    end
  end

  // Output register: one-cycle valid pulse; tag and value hold afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_rob_q   <= '0;
      out_value_q <= '0;
    end else if (flush_i) begin
      out_valid_q <= 1'b0;
    end else if (rdy_i) begin
      out_valid_q <= 1'b0;
`ifdef ALU_MULDIV_EN
      if (state_q == S_DONE) begin
        out_valid_q <= 1'b1;
        out_rob_q   <= tag_q;
        out_value_q <= is_rem_q ? rem_fix : quo_fix;
      end else
`endif
      if (accept && completes_now) begin
        out_valid_q <= 1'b1;
        out_rob_q   <= bus.in_rob_id;
        out_value_q <= res_now;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_rob_id = out_rob_q;
  assign bus.out_value  = out_value_q;
endmodule
`default_nettype wire
